// File: rtl/stage5_wb_param.sv
// Writeback/commit stage: holds one instruction, resolves exceptions through a
// priority/ecode table, waits out a multi-cycle CSR read and commits to RF/CSR.
module stage5_wb_param #(
    parameter int DATA_W    = 32,
    parameter int CSR_NUM_W = 14,
    parameter int NUM_EXC   = 6,
    // slice [6i+5:6i] is the ecode of cause i: cause0=0x0, 1=0xd, 2=0x9, 3=0x8, 4=0xc, 5=0xb
    parameter logic [NUM_EXC*6-1:0] ECODE_TABLE = {6'hb, 6'hc, 6'h8, 6'h9, 6'hd, 6'h0},
    parameter int CSR_RD_LAT = 0,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_to_ws_valid,
    output logic                  ws_allow_in,
    input  logic [DATA_W-1:0]     ms_pc,
    input  logic                  ms_gr_we,
    input  logic [4:0]            ms_dest,
    input  logic [DATA_W-1:0]     ms_result,
    input  logic                  ms_csr_re,
    input  logic                  ms_csr_we,
    input  logic [CSR_NUM_W-1:0]  ms_csr_num,
    input  logic [DATA_W-1:0]     ms_csr_wmask,
    input  logic [DATA_W-1:0]     ms_csr_wvalue,
    input  logic                  ms_ertn,
    input  logic [NUM_EXC-1:0]    ms_exc_vec,
    input  logic [8:0]            ms_esubcode,
    input  logic [DATA_W-1:0]     ms_vaddr,
    output logic [CSR_NUM_W-1:0]  csr_num,
    output logic                  csr_re,
    input  logic [DATA_W-1:0]     csr_rvalue,
    output logic                  csr_we,
    output logic [DATA_W-1:0]     csr_wmask,
    output logic [DATA_W-1:0]     csr_wvalue,
    output logic                  ertn_flush,
    output logic                  wb_ex,
    output logic [5:0]            wb_ecode,
    output logic [8:0]            wb_esubcode,
    output logic [DATA_W-1:0]     wb_pc,
    output logic [DATA_W-1:0]     wb_vaddr,
    output logic                  fwd_valid,
    output logic                  fwd_ready,
    output logic [4:0]            fwd_dest,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      instret,
    output logic [DATA_W-1:0]     debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic                 gr_we;
        logic [4:0]           dest;
        logic [DATA_W-1:0]    result;
        logic                 csr_re;
        logic                 csr_we;
        logic [CSR_NUM_W-1:0] csr_num;
        logic [DATA_W-1:0]    csr_wmask;
        logic [DATA_W-1:0]    csr_wvalue;
        logic                 ertn;
        logic [NUM_EXC-1:0]   exc_vec;
        logic [8:0]           esubcode;
        logic [DATA_W-1:0]    vaddr;
    } ws_payload_t;

    localparam logic [1:0] LAT = 2'(CSR_RD_LAT);

    ws_payload_t       pl, pl_in;
    logic              ws_valid;
    logic [1:0]        rd_cnt;
    logic              any_exc, ready_go, retire, flush, accept, rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [5:0]        ecode;

    assign pl_in = {ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re, ms_csr_we, ms_csr_num,
                    ms_csr_wmask, ms_csr_wvalue, ms_ertn, ms_exc_vec, ms_esubcode, ms_vaddr};

    assign any_exc     = |pl.exc_vec;
    assign ready_go    = any_exc | !pl.csr_re | (rd_cnt == LAT);
    assign ws_allow_in = !ws_valid | ready_go;
    assign retire      = ws_valid & ready_go & !any_exc;
    assign wb_ex       = ws_valid & any_exc;
    assign ertn_flush  = retire & pl.ertn;
    assign flush       = wb_ex | ertn_flush;
    assign accept      = ms_to_ws_valid & ws_allow_in & !flush;

    // Walk from the lowest-priority cause upward so the lowest set bit wins.
    always_comb begin
        ecode = 6'h0;
        for (int i = NUM_EXC - 1; i >= 0; i--)
            if (pl.exc_vec[i]) ecode = ECODE_TABLE[6*i +: 6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            pl       <= '0;
            rd_cnt   <= 2'd0;
            instret  <= '0;
        end else begin
            if (accept) begin
                ws_valid <= 1'b1;
                pl       <= pl_in;
                rd_cnt   <= 2'd0;
            end else begin
                if (ready_go) ws_valid <= 1'b0;
                if (ws_valid && pl.csr_re && !any_exc && rd_cnt < LAT)
                    rd_cnt <= rd_cnt + 2'd1;
            end
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    assign csr_re      = ws_valid & pl.csr_re;
    assign csr_we      = retire & pl.csr_we;
    assign csr_num     = pl.csr_num;
    assign csr_wmask   = pl.csr_wmask;
    assign csr_wvalue  = pl.csr_wvalue;
    assign rf_we       = retire & pl.gr_we;
    assign rf_wdata    = csr_re ? csr_rvalue : pl.result;

    assign wb_ecode    = ecode;
    assign wb_esubcode = pl.esubcode;
    assign wb_pc       = pl.pc;
    assign wb_vaddr    = pl.vaddr;

    // fwd_ready is qualified by ws_valid so an empty stage drives all zeros.
    assign fwd_valid   = ws_valid & pl.gr_we & !any_exc;
    assign fwd_ready   = ws_valid & ready_go;
    assign fwd_dest    = pl.dest;
    assign fwd_data    = rf_wdata;

    assign debug_wb_pc       = pl.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = pl.dest;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_stage5_wb_param.sv
// Bench for stage5_wb_param (CSR_RD_LAT=2, CNT_W=4): directed scenarios plus
// randomized traffic against a transaction-level commit model.
module tb_stage5_wb_param;
    localparam int LAT = 2;

    logic        clk, reset, ms_to_ws_valid, ws_allow_in;
    logic [31:0] ms_pc, ms_result, ms_csr_wmask, ms_csr_wvalue, ms_vaddr;
    logic        ms_gr_we, ms_csr_re, ms_csr_we, ms_ertn;
    logic [4:0]  ms_dest;
    logic [13:0] ms_csr_num, csr_num;
    logic [5:0]  ms_exc_vec, wb_ecode;
    logic [8:0]  ms_esubcode, wb_esubcode;
    logic        csr_re, csr_we, ertn_flush, wb_ex, fwd_valid, fwd_ready;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, wb_pc, wb_vaddr, fwd_data;
    logic [4:0]  fwd_dest, debug_wb_rf_wnum;
    logic [3:0]  instret, debug_wb_rf_we;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;

    typedef struct {
        logic [31:0] pc;   logic gr_we; logic [4:0] dest; logic [31:0] result;
        logic csr_re; logic csr_we; logic [13:0] csr_num; logic [31:0] wvalue;
        logic ertn; logic [5:0] exc; logic [8:0] esub;
    } instr_t;

    int errs = 0, checks = 0;
    int exp_ret = 0;
    logic [5:0] ecodes [6] = '{6'h0, 6'hd, 6'h9, 6'h8, 6'hc, 6'hb};
    instr_t q[$];

    stage5_wb_param #(.DATA_W(32), .CSR_NUM_W(14), .NUM_EXC(6), .CSR_RD_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_ertn(ms_ertn),
        .ms_exc_vec(ms_exc_vec), .ms_esubcode(ms_esubcode), .ms_vaddr(ms_vaddr),
        .csr_num(csr_num), .csr_re(csr_re), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .ertn_flush(ertn_flush), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .instret(instret), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: read data becomes valid LAT cycles after csr_re rises for a given PC.
    int hold = 0;
    logic [31:0] prev_pc = 32'h0;
    always @(posedge clk) begin
        if (csr_re) hold <= (debug_wb_pc == prev_pc) ? hold + 1 : 1;
        else        hold <= 0;
        prev_pc <= debug_wb_pc;
    end
    function automatic logic [31:0] csr_val(input logic [13:0] n);
        return 32'h5a5a0000 | {18'h0, n};
    endfunction
    assign csr_rvalue = (csr_re && hold == LAT) ? csr_val(csr_num) : 32'hbad0bad0;

    function automatic logic [5:0] ecode_of(input logic [5:0] exc);
        for (int i = 0; i < 6; i++) if (exc[i]) return ecodes[i];
        return 6'h0;
    endfunction

    function automatic instr_t alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res);
        instr_t t;
        t = '{pc: pc, gr_we: 1'b1, dest: dest, result: res, csr_re: 1'b0, csr_we: 1'b0,
              csr_num: 14'h0, wvalue: 32'h0, ertn: 1'b0, exc: 6'h0, esub: 9'h0};
        return t;
    endfunction

    task automatic idle();
        ms_to_ws_valid = 0; ms_pc = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
        ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wmask = 0; ms_csr_wvalue = 0;
        ms_ertn = 0; ms_exc_vec = 0; ms_esubcode = 0; ms_vaddr = 0;
    endtask

    task automatic drive(input instr_t t);
        ms_to_ws_valid = 1; ms_pc = t.pc; ms_gr_we = t.gr_we; ms_dest = t.dest;
        ms_result = t.result; ms_csr_re = t.csr_re; ms_csr_we = t.csr_we;
        ms_csr_num = t.csr_num; ms_csr_wmask = 32'hffffffff; ms_csr_wvalue = t.wvalue;
        ms_ertn = t.ertn; ms_exc_vec = t.exc; ms_esubcode = t.esub; ms_vaddr = t.pc ^ 32'h55;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0; exp_ret = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ws_allow_in !== 1'b1) begin errs++; $display("FAIL reset_allow_in got=%b exp=1", ws_allow_in); end
        checks++;
        if ({wb_ex, ertn_flush, csr_re, csr_we, fwd_valid, fwd_ready, debug_wb_rf_we} !== 10'h0) begin
            errs++; $display("FAIL reset_strobes got=%b exp=0",
                {wb_ex, ertn_flush, csr_re, csr_we, fwd_valid, fwd_ready, debug_wb_rf_we});
        end
        checks++;
        if ({instret, debug_wb_pc, debug_wb_rf_wdata, wb_ecode, csr_num} !== 60'h0) begin
            errs++; $display("FAIL reset_values got=%h exp=0",
                {instret, debug_wb_pc, debug_wb_rf_wdata, wb_ecode, csr_num});
        end
        reset = 0; exp_ret = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(alu(32'h1c000000 + 32'(4*i), 5'(i+1), 32'h100 + 32'(i)));
            @(negedge clk);
            checks++;
            if ({debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wdata} !== {4'hf, 32'h1c000000 + 32'(4*i), 32'h100 + 32'(i)}) begin
                errs++; $display("FAIL b2b_commit%0d got we=%h pc=%h d=%h exp we=f pc=%h", i,
                    debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wdata, 32'h1c000000 + 32'(4*i));
            end
        end
        idle(); exp_ret += 3;
        @(negedge clk);
        checks++;
        if ({debug_wb_rf_we, instret} !== {4'h0, 4'(exp_ret)}) begin
            errs++; $display("FAIL b2b_instret got we=%h instret=%0d exp we=0 instret=%0d", debug_wb_rf_we, instret, exp_ret);
        end
    endtask

    task automatic test_csr_wait();
        instr_t t;
        t = alu(32'h1c000100, 5'd4, 32'h0); t.csr_re = 1; t.csr_num = 14'h5;
        drive(t);
        @(negedge clk);
        checks++;
        if ({ws_allow_in, fwd_valid, fwd_ready, csr_re, debug_wb_rf_we} !== {4'b0101, 4'h0}) begin
            errs++; $display("FAIL csr_wait0 got allow=%b fv=%b fr=%b re=%b we=%h exp 0 1 0 1 0",
                ws_allow_in, fwd_valid, fwd_ready, csr_re, debug_wb_rf_we);
        end
        drive(alu(32'h1c000104, 5'd7, 32'h77));
        @(negedge clk);
        checks++;
        if ({ws_allow_in, fwd_valid, fwd_ready, debug_wb_rf_we} !== {3'b010, 4'h0}) begin
            errs++; $display("FAIL csr_wait1 got allow=%b fv=%b fr=%b we=%h exp 0 1 0 0",
                ws_allow_in, fwd_valid, fwd_ready, debug_wb_rf_we);
        end
        @(negedge clk);
        checks++;
        if ({ws_allow_in, fwd_ready, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {2'b11, 4'hf, 5'd4, csr_val(14'h5)}) begin
            errs++; $display("FAIL csr_commit got allow=%b fr=%b we=%h wnum=%0d d=%h exp 1 1 f 4 %h",
                ws_allow_in, fwd_ready, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, csr_val(14'h5));
        end
        exp_ret += 1;
        @(negedge clk);
        checks++;
        if ({debug_wb_pc, debug_wb_rf_wdata, instret} !== {32'h1c000104, 32'h77, 4'(exp_ret)}) begin
            errs++; $display("FAIL csr_next got pc=%h d=%h instret=%0d exp pc=1c000104 d=77 instret=%0d",
                debug_wb_pc, debug_wb_rf_wdata, instret, exp_ret);
        end
        idle(); exp_ret += 1;
        @(negedge clk);
    endtask

    task automatic test_exception();
        instr_t t;
        t = alu(32'h1c000200, 5'd3, 32'h33); t.exc = 6'b100010; t.esub = 9'h5;
        drive(t);
        @(negedge clk);
        checks++;
        if ({wb_ex, wb_ecode, wb_esubcode, debug_wb_rf_we, wb_pc, instret} !== {1'b1, 6'hd, 9'h5, 4'h0, 32'h1c000200, 4'(exp_ret)}) begin
            errs++; $display("FAIL exc_commit got ex=%b ec=%h sub=%h we=%h pc=%h ir=%0d exp 1 d 5 0 1c000200 %0d",
                wb_ex, wb_ecode, wb_esubcode, debug_wb_rf_we, wb_pc, instret, exp_ret);
        end
        drive(alu(32'h1c000204, 5'd5, 32'h55));
        @(negedge clk);
        checks++;
        if ({wb_ex, debug_wb_rf_we, ws_allow_in, fwd_valid} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
            errs++; $display("FAIL exc_drop got ex=%b we=%h allow=%b fv=%b exp 0 0 1 0",
                wb_ex, debug_wb_rf_we, ws_allow_in, fwd_valid);
        end
        drive(alu(32'h1c000208, 5'd6, 32'h66));
        @(negedge clk);
        checks++;
        if ({debug_wb_rf_we, debug_wb_pc} !== {4'hf, 32'h1c000208}) begin
            errs++; $display("FAIL exc_resume got we=%h pc=%h exp we=f pc=1c000208", debug_wb_rf_we, debug_wb_pc);
        end
        idle(); exp_ret += 1;
    endtask

    task automatic test_ertn();
        instr_t t;
        t = alu(32'h1c000300, 5'd0, 32'h0); t.gr_we = 0; t.ertn = 1; t.exc = 6'b100000;
        drive(t);
        @(negedge clk);
        checks++;
        if ({wb_ex, wb_ecode, ertn_flush} !== {1'b1, 6'hb, 1'b0}) begin
            errs++; $display("FAIL ertn_exc got ex=%b ec=%h ef=%b exp 1 b 0", wb_ex, wb_ecode, ertn_flush);
        end
        idle();
        @(negedge clk);
        t.exc = 6'h0; t.pc = 32'h1c000304;
        drive(t);
        @(negedge clk);
        checks++;
        if ({ertn_flush, csr_we, wb_ex} !== 3'b100) begin
            errs++; $display("FAIL ertn_plain got ef=%b cwe=%b ex=%b exp 1 0 0", ertn_flush, csr_we, wb_ex);
        end
        idle(); exp_ret += 1;
        @(negedge clk);
        checks++;
        if (ertn_flush !== 1'b0) begin errs++; $display("FAIL ertn_pulse got ef=%b exp 0", ertn_flush); end
    endtask

    task automatic test_random();
        instr_t cur, e;
        logic have;
        int sent, budget;
        logic [31:0] exp_d;
        do_reset();
        have = 0; sent = 0; budget = 3000;
        while ((sent < 80 || have || q.size() != 0) && budget > 0) begin
            budget--;
            if (wb_ex || debug_wb_rf_we[0] || csr_we || ertn_flush) begin
                checks++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL rnd_unexpected got commit pc=%h exp none", debug_wb_pc);
                end else begin
                    e = q.pop_front();
                    if (e.exc != 0) begin
                        if ({wb_ex, wb_ecode, wb_esubcode, debug_wb_rf_we[0], csr_we, ertn_flush, debug_wb_pc} !==
                            {1'b1, ecode_of(e.exc), e.esub, 3'b000, e.pc}) begin
                            errs++; $display("FAIL rnd_exc got ex=%b ec=%h sub=%h we=%b cwe=%b ef=%b pc=%h exp ec=%h pc=%h",
                                wb_ex, wb_ecode, wb_esubcode, debug_wb_rf_we[0], csr_we, ertn_flush, debug_wb_pc,
                                ecode_of(e.exc), e.pc);
                        end
                    end else begin
                        exp_d = e.csr_re ? csr_val(e.csr_num) : e.result;
                        exp_ret = (exp_ret + 1) % 16;
                        if ({wb_ex, debug_wb_rf_we[0], csr_we, ertn_flush, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, csr_wvalue} !==
                            {1'b0, e.gr_we, e.csr_we, e.ertn, e.pc, e.dest, exp_d, e.wvalue}) begin
                            errs++; $display("FAIL rnd_retire got we=%b cwe=%b ef=%b pc=%h n=%0d d=%h exp we=%b cwe=%b ef=%b pc=%h n=%0d d=%h",
                                debug_wb_rf_we[0], csr_we, ertn_flush, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata,
                                e.gr_we, e.csr_we, e.ertn, e.pc, e.dest, exp_d);
                        end
                    end
                end
            end
            if (!have) begin
                if (sent < 80 && $urandom_range(0, 3) != 0) begin
                    cur = alu(32'h1c001000 + 32'(4*sent), 5'($urandom), $urandom);
                    cur.gr_we = 1'($urandom); cur.csr_re = ($urandom_range(0, 2) == 0);
                    cur.csr_we = ($urandom_range(0, 3) == 0); cur.ertn = ($urandom_range(0, 7) == 0);
                    cur.csr_num = 14'($urandom); cur.wvalue = $urandom; cur.esub = 9'($urandom);
                    cur.exc = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
                    if (!(cur.gr_we || cur.csr_we || cur.ertn || cur.exc != 0)) cur.gr_we = 1;
                    drive(cur); have = 1; sent++;
                end else idle();
            end
            if (have && ws_allow_in) begin
                if (!(wb_ex || ertn_flush)) q.push_back(cur);
                have = 0;
            end
            @(negedge clk);
        end
        idle();
        checks++;
        if (budget == 0) begin errs++; $display("FAIL rnd_timeout got left=%0d exp 0", q.size()); end
        @(negedge clk);
        checks++;
        if (instret !== 4'(exp_ret)) begin errs++; $display("FAIL rnd_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(alu(32'h1c002000 + 32'(4*i), 5'd9, 32'(i)));
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        checks++;
        if (instret !== 4'(17 % 16)) begin errs++; $display("FAIL wrap_instret got=%0d exp=%0d", instret, 17 % 16); end
    endtask

    task automatic test_reset_mid_wait();
        instr_t t;
        int pulses;
        t = alu(32'h1c000500, 5'd8, 32'h0); t.csr_re = 1; t.csr_we = 1; t.csr_num = 14'h7;
        drive(t);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++;
        if ({ws_allow_in, csr_re} !== 2'b01) begin
            errs++; $display("FAIL rstwait_hold got allow=%b re=%b exp 0 1", ws_allow_in, csr_re);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({ws_allow_in, csr_re, csr_we, debug_wb_rf_we, fwd_valid, instret, debug_wb_pc} !== {1'b1, 43'h0}) begin
            errs++; $display("FAIL rstwait_clear got allow=%b re=%b cwe=%b we=%h fv=%b ir=%0d pc=%h exp 1 0",
                ws_allow_in, csr_re, csr_we, debug_wb_rf_we, fwd_valid, instret, debug_wb_pc);
        end
        reset = 0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (csr_we || debug_wb_rf_we[0]) pulses++;
        end
        checks++;
        if (pulses != 0) begin errs++; $display("FAIL rstwait_pulse got=%0d exp=0", pulses); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_csr_wait();
        test_exception();
        test_ertn();
        test_random();
        test_wrap();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
